// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM serial link (mux transmit side and demux receive side).
package tdm_pkg;

  localparam int unsigned TDM_SLOTS  = 8;
  localparam int unsigned TDM_SLOT_W = 3;

  typedef logic [TDM_SLOT_W-1:0] slot_t;

  typedef enum logic {
    StHunt,
    StRecv
  } state_e;

  // Slot index arithmetic wraps modulo TDM_SLOTS because the width is exact.
  function automatic slot_t slot_inc(slot_t s);
    return s + slot_t'(1);
  endfunction

endpackage

// File: rtl/tdm_demux_1to8_if.sv
// Serial-in / frame-out bus of the 1-to-8 TDM demultiplexer.
interface tdm_demux_1to8_if;
  import tdm_pkg::*;

  logic                 din;
  logic                 din_valid;
  logic                 frame_sync;
  logic [TDM_SLOTS-1:0] q;
  logic                 q_valid;
  slot_t                slot;
  logic                 sync_err;

  modport master (
    output din,
    output din_valid,
    output frame_sync,
    input  q,
    input  q_valid,
    input  slot,
    input  sync_err
  );

  modport slave (
    input  din,
    input  din_valid,
    input  frame_sync,
    output q,
    output q_valid,
    output slot,
    output sync_err
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Slot counter: enable, synchronous load-to-1 on sync, wrap flag at the last slot.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  load,
  output slot_t count,
  output logic  wrap
);

  slot_t cnt_q, cnt_d;

  // Load wins over enable: a sync bit is itself slot 0, so the next bit goes to slot 1.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = slot_t'(1);
    end else if (en) begin
      cnt_d = slot_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign wrap  = (cnt_q == slot_t'(TDM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux_1to8.sv
// Receive end of the 8-to-1 TDM link: collects 8 serial slot bits and presents them as a frame.
module tdm_demux_1to8
  import tdm_pkg::*;
#(
  parameter bit REQUIRE_SYNC = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  tdm_demux_1to8_if.slave  bus
);

  localparam state_e ResetState = REQUIRE_SYNC ? StHunt : StRecv;

  state_e               state_q;
  logic [TDM_SLOTS-1:0] shadow_q;
  logic [TDM_SLOTS-1:0] q_q;
  logic                 q_valid_q;
  logic                 sync_err_q;

  slot_t slot;
  logic  wrap;
  logic  cnt_en;
  logic  cnt_load;

  assign cnt_load = bus.din_valid & bus.frame_sync;
  assign cnt_en   = bus.din_valid & ~bus.frame_sync & (state_q == StRecv);

  tdm_slot_counter u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .load  (cnt_load),
    .count (slot),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ResetState;
      shadow_q   <= '0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      q_valid_q  <= 1'b0;
      sync_err_q <= 1'b0;
      if (bus.din_valid) begin
        if (bus.frame_sync) begin
          // Sync always restarts at slot 0; only a mid-frame restart is an error.
          shadow_q[0] <= bus.din;
          state_q     <= StRecv;
          if (state_q == StRecv && slot != '0) begin
            sync_err_q <= 1'b1;
          end
        end else if (state_q == StRecv) begin
          shadow_q[slot] <= bus.din;
          if (wrap) begin
            q_q       <= {bus.din, shadow_q[TDM_SLOTS-2:0]};
            q_valid_q <= 1'b1;
            if (REQUIRE_SYNC) begin
              state_q <= StHunt;
            end
          end
        end
      end
    end
  end

  assign bus.q        = q_q;
  assign bus.q_valid  = q_valid_q;
  assign bus.slot     = slot;
  assign bus.sync_err = sync_err_q;

  a_valid_err_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(q_valid_q && sync_err_q));

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Bench for tdm_demux_1to8: sync-required and free-running instances, scoreboarded frames.
module tb_tdm_demux_1to8;
  import tdm_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  tdm_demux_1to8_if s_bus ();
  tdm_demux_1to8_if f_bus ();

  tdm_demux_1to8 #(.REQUIRE_SYNC(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_bus.slave)
  );

  tdm_demux_1to8 #(.REQUIRE_SYNC(1'b0)) u_free (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (f_bus.slave)
  );

  typedef struct {
    logic [7:0] q;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    int         gap_after;
    int         gap_len;
    logic [7:0] exp_q;
  } vec_t;

  exp_t s_q[$];
  exp_t f_q[$];
  int   err_q[$];
  vec_t tbl[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus on the chosen bus; returns one clock later at posedge+1.
  task automatic drive_bit(input bit sel, input logic d, input logic v, input logic fs);
    if (sel) begin
      f_bus.din = d; f_bus.din_valid = v; f_bus.frame_sync = fs;
    end else begin
      s_bus.din = d; s_bus.din_valid = v; s_bus.frame_sync = fs;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] data, input logic [7:0] exp_q,
                            input bit sync, input int gap_after, input int gap_len);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        e.q   = exp_q;
        e.cyc = ncyc + 2;
        if (sel) f_q.push_back(e);
        else     s_q.push_back(e);
      end
      drive_bit(sel, data[k], 1'b1, sync && (k == 0));
      check(sel ? "f slot" : "s slot", sel ? f_bus.slot : s_bus.slot, (k + 1) % 8);
      if (k == gap_after) begin
        // Idle gap; frame_sync without din_valid must be ignored.
        for (int g = 0; g < gap_len; g++) drive_bit(sel, 1'b1, 1'b0, 1'b1);
      end
    end
  endtask

  // Monitor: pop expected frames / sync errors when the DUT produces them.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (s_bus.q_valid) begin
        if (s_q.size() == 0) begin
          check("s unexpected q_valid", 32'd1, 32'd0);
        end else begin
          e = s_q.pop_front();
          check("s q", s_bus.q, e.q);
          check("s q_valid cycle", ncyc, e.cyc);
        end
      end
      if (f_bus.q_valid) begin
        if (f_q.size() == 0) begin
          check("f unexpected q_valid", 32'd1, 32'd0);
        end else begin
          e = f_q.pop_front();
          check("f q", f_bus.q, e.q);
          check("f q_valid cycle", ncyc, e.cyc);
        end
      end
      if (s_bus.sync_err) begin
        if (err_q.size() == 0) check("s unexpected sync_err", 32'd1, 32'd0);
        else check("s sync_err cycle", ncyc, err_q.pop_front());
      end
      if (f_bus.sync_err) check("f unexpected sync_err", 32'd1, 32'd0);
    end
  end

  initial begin
    vec_t v;
    s_bus.din = 1'b0; s_bus.din_valid = 1'b0; s_bus.frame_sync = 1'b0;
    f_bus.din = 1'b0; f_bus.din_valid = 1'b0; f_bus.frame_sync = 1'b0;

    v = '{8'h01, -1, 0, 8'h01}; tbl.push_back(v);
    for (int k = 0; k < 8; k++) begin
      v.data = 8'h01 << k; v.gap_after = -1; v.gap_len = 0; v.exp_q = 8'h01 << k;
      tbl.push_back(v);
    end
    v = '{8'h01, 3, 3, 8'h01}; tbl.push_back(v);
    v = '{8'h5C, -1, 0, 8'h5C}; tbl.push_back(v);
    v = '{8'hFF, 5, 1, 8'hFF}; tbl.push_back(v);
    v = '{8'h00, -1, 0, 8'h00}; tbl.push_back(v);

    repeat (3) @(posedge clk);
    #1;
    check("reset s q", s_bus.q, 8'h00);
    check("reset s q_valid", s_bus.q_valid, 0);
    check("reset s slot", s_bus.slot, 0);
    check("reset s sync_err", s_bus.sync_err, 0);
    check("reset f q", f_bus.q, 8'h00);
    check("reset f slot", f_bus.slot, 0);
    rst_n = 1'b1;
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0);

    // Hunting: valid bits without sync are discarded.
    for (int k = 0; k < 3; k++) begin
      drive_bit(1'b0, 1'b1, 1'b1, 1'b0);
      check("hunt s slot", s_bus.slot, 0);
    end

    // Back-to-back table frames, each starting with frame_sync.
    foreach (tbl[i]) begin
      send_frame(1'b0, tbl[i].data, tbl[i].exp_q, 1'b1, tbl[i].gap_after, tbl[i].gap_len);
    end
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    check("s q hold", s_bus.q, 8'h00);

    // Early sync: partial frame of 5 bits, then resync carrying 8'hA5.
    send_frame(1'b0, 8'h3C, 8'h3C, 1'b1, -1, 0);
    for (int k = 0; k < 5; k++) drive_bit(1'b0, 1'b1, 1'b1, k == 0);
    check("early s slot", s_bus.slot, 5);
    err_q.push_back(ncyc + 2);
    send_frame(1'b0, 8'hA5, 8'hA5, 1'b1, -1, 0);
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame after slot 4.
    for (int k = 0; k < 5; k++) drive_bit(1'b0, 1'b0, 1'b1, k == 0);
    check("pre-rst s slot", s_bus.slot, 5);
    check("pre-rst s q", s_bus.q, 8'hA5);
    rst_n = 1'b0;
    #1;
    check("mid-rst s q", s_bus.q, 8'h00);
    check("mid-rst s q_valid", s_bus.q_valid, 0);
    check("mid-rst s slot", s_bus.slot, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive_bit(1'b0, 1'b1, 1'b1, 1'b0);
      check("post-rst s slot", s_bus.slot, 0);
    end
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    check("post-rst s q", s_bus.q, 8'h00);

    // Free-running instance: 16 continuous bits, no sync.
    send_frame(1'b1, 8'h3C, 8'h3C, 1'b0, -1, 0);
    send_frame(1'b1, 8'hC5, 8'hC5, 1'b0, -1, 0);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);

    repeat (5) drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    check("s frames pending", s_q.size(), 0);
    check("f frames pending", f_q.size(), 0);
    check("sync_err pending", err_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
